// File: rtl/sim_ctrl.sv
// sim_ctrl: sequences core reset, counts RUN cycles and raises a sticky finish with a verdict
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   restart               synchronous soft restart pulse
//   mon_valid/addr/data   core I/O write bus being watched
//   sys_rst               active-high reset to the core
//   finish, status        sticky end flag and verdict (0 HOLD,1 RUN,2 PASS,3 FAIL,4 TIMEOUT,5 STALL)
//   exit_code             data byte of the exit write
//   cycle_cnt, byte_cnt   RUN cycles elapsed, non-exit writes seen in RUN
module sim_ctrl #(
  parameter int unsigned       RST_CYCLES     = 5,
  parameter int unsigned       TIMEOUT_CYCLES = 15000000,
  parameter int unsigned       IDLE_LIMIT     = 0,
  parameter int unsigned       ADDR_W         = 18,
  parameter logic [ADDR_W-1:0] EXIT_ADDR      = 18'h30004,
  parameter int unsigned       CNT_W          = 32,
  parameter bit                HOLD_ON_DONE   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              mon_valid,
  input  logic [ADDR_W-1:0] mon_addr,
  input  logic [7:0]        mon_data,
  output logic              sys_rst,
  output logic              finish,
  output logic [2:0]        status,
  output logic [7:0]        exit_code,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  byte_cnt
);
  localparam int HW = $clog2(RST_CYCLES + 1);
  typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;
  state_t            state, state_nx;
  logic [HW-1:0]     hold_cnt, hold_nx;
  logic [CNT_W-1:0]  idle_cnt, idle_nx, cycle_nx, byte_nx;
  logic              sys_rst_nx, finish_nx;
  logic [2:0]        status_nx;
  logic [7:0]        exit_nx;
  logic              hold_done, ev_exit, ev_to, ev_stall, ev;
  assign hold_done = state == HOLD && hold_cnt == HW'(RST_CYCLES - 1);
  assign ev_exit   = state == RUN && mon_valid && mon_addr == EXIT_ADDR;
  assign ev_to     = state == RUN && TIMEOUT_CYCLES != 0 && cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  assign ev_stall  = state == RUN && IDLE_LIMIT != 0 && !mon_valid && idle_cnt == CNT_W'(IDLE_LIMIT - 1);
  assign ev        = ev_exit || ev_to || ev_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HOLD;
      hold_cnt  <= '0;
      idle_cnt  <= '0;
      cycle_cnt <= '0;
      byte_cnt  <= '0;
      sys_rst   <= 1'b1;
      finish    <= 1'b0;
      status    <= 3'd0;
      exit_code <= '0;
    end else begin
      state     <= state_nx;
      hold_cnt  <= hold_nx;
      idle_cnt  <= idle_nx;
      cycle_cnt <= cycle_nx;
      byte_cnt  <= byte_nx;
      sys_rst   <= sys_rst_nx;
      finish    <= finish_nx;
      status    <= status_nx;
      exit_code <= exit_nx;
    end
  end

  always_comb
    state_nx = restart ? HOLD : hold_done ? RUN : ev ? DONE : state;

  always_comb begin
    hold_nx    = hold_cnt;
    idle_nx    = idle_cnt;
    cycle_nx   = cycle_cnt;
    byte_nx    = byte_cnt;
    sys_rst_nx = sys_rst;
    finish_nx  = finish;
    status_nx  = status;
    exit_nx    = exit_code;
    if (restart) begin
      hold_nx    = '0;
      idle_nx    = '0;
      cycle_nx   = '0;
      byte_nx    = '0;
      sys_rst_nx = 1'b1;
      finish_nx  = 1'b0;
      status_nx  = 3'd0;
      exit_nx    = '0;
    end else if (state == HOLD) begin
      hold_nx    = hold_cnt + 1'b1;
      sys_rst_nx = !hold_done;
      status_nx  = hold_done ? 3'd1 : 3'd0;
    end else if (state == RUN) begin
      cycle_nx = cycle_cnt + 1'b1;
      idle_nx  = mon_valid ? '0 : idle_cnt + 1'b1;
      byte_nx  = (mon_valid && !ev_exit) ? byte_cnt + 1'b1 : byte_cnt;
      exit_nx  = ev_exit ? mon_data : exit_code;
      if (ev) begin
        finish_nx  = 1'b1;
        sys_rst_nx = HOLD_ON_DONE;
        status_nx  = ev_exit ? (mon_data == 8'd0 ? 3'd2 : 3'd3) : ev_to ? 3'd4 : 3'd5;
      end
    end
  end
endmodule

// File: tb/tb_sim_ctrl.sv
// tb_sim_ctrl: directed self-checking bench for sim_ctrl in exit, timeout and stall configurations
module tb_sim_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        restart = 1'b0;
  logic        mon_valid = 1'b0;
  logic [17:0] mon_addr = '0;
  logic [7:0]  mon_data = '0;
  logic        sys_rst[3];
  logic        finish[3];
  logic [2:0]  status[3];
  logic [7:0]  exit_code[3];
  logic [31:0] cycle_cnt[3];
  logic [31:0] byte_cnt[3];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sim_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .restart(restart), .mon_valid(mon_valid), .mon_addr(mon_addr),
    .mon_data(mon_data), .sys_rst(sys_rst[0]), .finish(finish[0]), .status(status[0]),
    .exit_code(exit_code[0]), .cycle_cnt(cycle_cnt[0]), .byte_cnt(byte_cnt[0]));

  sim_ctrl #(.TIMEOUT_CYCLES(100), .HOLD_ON_DONE(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .restart(restart), .mon_valid(mon_valid), .mon_addr(mon_addr),
    .mon_data(mon_data), .sys_rst(sys_rst[1]), .finish(finish[1]), .status(status[1]),
    .exit_code(exit_code[1]), .cycle_cnt(cycle_cnt[1]), .byte_cnt(byte_cnt[1]));

  sim_ctrl #(.TIMEOUT_CYCLES(0), .IDLE_LIMIT(10)) u2 (
    .clk(clk), .rst_n(rst_n), .restart(restart), .mon_valid(mon_valid), .mon_addr(mon_addr),
    .mon_data(mon_data), .sys_rst(sys_rst[2]), .finish(finish[2]), .status(status[2]),
    .exit_code(exit_code[2]), .cycle_cnt(cycle_cnt[2]), .byte_cnt(byte_cnt[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic v, input logic [17:0] a, input logic [7:0] d);
    mon_valid = v;
    mon_addr  = a;
    mon_data  = d;
    tick;
    mon_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 18'h0, 8'h0);
  endtask

  task automatic hold_seq(input string tag);
    for (int e = 1; e <= 5; e++) begin
      tick;
      chk(tag, {31'b0, sys_rst[0]}, (e < 5) ? 32'd1 : 32'd0);
    end
    chk({tag, "_status"}, {29'b0, status[0]}, 32'd1);
  endtask

  task automatic boot;
    restart   = 1'b0;
    mon_valid = 1'b0;
    rst_n     = 1'b0;
    #2;
    rst_n = 1'b1;
    repeat (5) tick;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_sys_rst", {31'b0, sys_rst[0]}, 32'd1);
    chk("rst_status", {29'b0, status[0]}, 32'd0);
    chk("rst_finish", {31'b0, finish[0]}, 32'd0);
    chk("rst_cycle", cycle_cnt[0], 32'd0);
    chk("rst_byte", byte_cnt[0], 32'd0);
    chk("rst_exit", {24'b0, exit_code[0]}, 32'd0);
    rst_n = 1'b1;
    hold_seq("hold0");
    chk("run_cycle0", cycle_cnt[0], 32'd0);
    for (int k = 1; k <= 39; k++) cyc(k == 5 || k == 9 || k == 20, 18'h30000, 8'h41);
    cyc(1'b1, 18'h30004, 8'h00);
    chk("pass_byte", byte_cnt[0], 32'd3);
    chk("pass_status", {29'b0, status[0]}, 32'd2);
    chk("pass_exit", {24'b0, exit_code[0]}, 32'd0);
    chk("pass_cycle", cycle_cnt[0], 32'd40);
    chk("pass_finish", {31'b0, finish[0]}, 32'd1);
    chk("pass_sys_rst", {31'b0, sys_rst[0]}, 32'd1);
    cyc(1'b1, 18'h30000, 8'h01);
    cyc(1'b1, 18'h30004, 8'h05);
    chk("done_cycle", cycle_cnt[0], 32'd40);
    chk("done_byte", byte_cnt[0], 32'd3);
    chk("done_status", {29'b0, status[0]}, 32'd2);
    chk("done_exit", {24'b0, exit_code[0]}, 32'd0);
    restart = 1'b1;
    tick;
    restart = 1'b0;
    chk("rs_done_status", {29'b0, status[0]}, 32'd0);
    chk("rs_done_finish", {31'b0, finish[0]}, 32'd0);
    chk("rs_done_cycle", cycle_cnt[0], 32'd0);
    chk("rs_done_byte", byte_cnt[0], 32'd0);
    chk("rs_done_exit", {24'b0, exit_code[0]}, 32'd0);
    hold_seq("hold1");
    idle(3);
    cyc(1'b1, 18'h30000, 8'h22);
    idle(2);
    chk("mid_cycle", cycle_cnt[0], 32'd6);
    chk("mid_byte", byte_cnt[0], 32'd1);
    restart = 1'b1;
    tick;
    restart = 1'b0;
    chk("rs_run_status", {29'b0, status[0]}, 32'd0);
    chk("rs_run_cycle", cycle_cnt[0], 32'd0);
    chk("rs_run_byte", byte_cnt[0], 32'd0);
    chk("rs_run_sys_rst", {31'b0, sys_rst[0]}, 32'd1);
    hold_seq("hold2");
    cyc(1'b1, 18'h30000, 8'h33);
    idle(3);
    chk("pre_rst_cycle", cycle_cnt[0], 32'd4);
    rst_n = 1'b0;
    #2;
    chk("async_sys_rst", {31'b0, sys_rst[0]}, 32'd1);
    chk("async_status", {29'b0, status[0]}, 32'd0);
    chk("async_cycle", cycle_cnt[0], 32'd0);
    chk("async_byte", byte_cnt[0], 32'd0);
    rst_n = 1'b1;
    boot;
    idle(99);
    chk("to_pre_finish", {31'b0, finish[1]}, 32'd0);
    chk("to_pre_cycle", cycle_cnt[1], 32'd99);
    idle(1);
    chk("to_status", {29'b0, status[1]}, 32'd4);
    chk("to_cycle", cycle_cnt[1], 32'd100);
    chk("to_finish", {31'b0, finish[1]}, 32'd1);
    chk("to_sys_rst", {31'b0, sys_rst[1]}, 32'd0);
    boot;
    idle(99);
    cyc(1'b1, 18'h30004, 8'h07);
    chk("to_exit_status", {29'b0, status[1]}, 32'd3);
    chk("to_exit_code", {24'b0, exit_code[1]}, 32'd7);
    chk("to_exit_cycle", cycle_cnt[1], 32'd100);
    boot;
    idle(2);
    cyc(1'b1, 18'h30000, 8'h44);
    idle(9);
    chk("st_pre_finish", {31'b0, finish[2]}, 32'd0);
    idle(1);
    chk("st_status", {29'b0, status[2]}, 32'd5);
    chk("st_cycle", cycle_cnt[2], 32'd13);
    chk("st_finish", {31'b0, finish[2]}, 32'd1);
    boot;
    idle(2);
    cyc(1'b1, 18'h30000, 8'h44);
    idle(9);
    cyc(1'b1, 18'h30000, 8'h45);
    chk("st_save_finish", {31'b0, finish[2]}, 32'd0);
    chk("st_save_status", {29'b0, status[2]}, 32'd1);
    chk("st_save_byte", byte_cnt[2], 32'd2);
    idle(9);
    chk("st2_pre_finish", {31'b0, finish[2]}, 32'd0);
    idle(1);
    chk("st2_status", {29'b0, status[2]}, 32'd5);
    chk("st2_cycle", cycle_cnt[2], 32'd23);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sim_ctrl.md
# sim_ctrl

Parametrised simulation-control block for the SoC testbench. It sequences core reset from a single system reset and counts run cycles. It watches the core's memory-mapped output writes for an exit command, a global timeout and an output-stall condition, then raises a sticky `finish` with a status code for the bench to act on. It sits between the bench's clock/reset generator and `riscv_top`'s reset input and I/O write bus. It replaces fixed reset-hold and fixed-delay `$finish` with configurable, observable logic.

## Interface
- `RST_CYCLES`, 5: rising edges `sys_rst` is held after `rst_n` release; legal range ≥1.
- `TIMEOUT_CYCLES`, 15000000: RUN cycles before a timeout verdict; 0 disables the timeout.
- `IDLE_LIMIT`, 0: consecutive RUN cycles without `mon_valid` before a stall verdict; 0 disables the stall check.
- `ADDR_W`, 18: width of the monitored I/O address.
- `EXIT_ADDR`, 18'h30004: address whose write terminates the run.
- `CNT_W`, 32: width of the cycle and byte counters.
- `HOLD_ON_DONE`, 1: when 1, `sys_rst` is reasserted in DONE to freeze the core.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `restart`  in  1  synchronous soft restart; must be a single-cycle pulse.
- `mon_valid`  in  1  core I/O write strobe, one write per cycle.
- `mon_addr`  in  ADDR_W  I/O write address.
- `mon_data`  in  8  I/O write data byte.
- `sys_rst`  out  1  active-high reset driven to the core.
- `finish`  out  1  sticky end-of-simulation flag.
- `status`  out  3  0 HOLD, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT, 5 STALL.
- `exit_code`  out  8  `mon_data` captured from the exit write.
- `cycle_cnt`  out  CNT_W  number of RUN cycles elapsed.
- `byte_cnt`  out  CNT_W  number of non-exit `mon_valid` writes seen in RUN.

## Operation
- The block has three states: HOLD, RUN and DONE. All outputs are registered.
- Reset values while `rst_n`=0, asynchronously:
  - state HOLD, `sys_rst`=1, `status`=0.
  - `finish`=0, `exit_code`=0.
  - all counters 0, including the internal `hold_cnt` and `idle_cnt`.
- HOLD:
  - `hold_cnt` increments each edge.
  - On the edge where `hold_cnt`==RST_CYCLES-1: state goes to RUN, `sys_rst`→0, `status`→1.
  - `mon_*` inputs are ignored.
- RUN, at each edge:
  - `cycle_cnt` increments. It wraps at 2^CNT_W and does not saturate.
  - If `mon_valid` is 1, `idle_cnt`←0; otherwise `idle_cnt` increments.
- RUN termination events, evaluated on the current cycle's inputs. Priority is exit > timeout > stall.
  - Exit: `mon_valid` with `mon_addr`==EXIT_ADDR. Sets `exit_code`←`mon_data`; `status`←2 if `mon_data`==0, else 3. `byte_cnt` is not incremented.
  - Timeout: TIMEOUT_CYCLES≠0 and `cycle_cnt`==TIMEOUT_CYCLES-1. Sets `status`←4.
  - Stall: IDLE_LIMIT≠0, `mon_valid`=0 and `idle_cnt`==IDLE_LIMIT-1. Sets `status`←5.
  - On any event: state goes to DONE, `finish`←1, and `cycle_cnt` still increments on that edge.
- A non-exit `mon_valid` in RUN increments `byte_cnt`.
- DONE:
  - All counters freeze; `finish` and `status` hold.
  - `sys_rst` = HOLD_ON_DONE.
  - `mon_*` inputs are ignored.
- `restart`=1 in any state, with top priority over termination events. On the next edge:
  - state goes to HOLD, `sys_rst`←1, `status`←0, `finish`←0.
  - all counters and `exit_code` clear.
- `rst_n` asserted mid-RUN or mid-DONE: immediate asynchronous return to reset values; no verdict is reported.

## Timing
- With `rst_n` released before edge 1, `sys_rst` is 1 through edge RST_CYCLES and 0 after it.
- The first RUN cycle is the cycle after edge RST_CYCLES.
- Verdict latency is one edge: an event in RUN cycle k sets `finish`=1 and `cycle_cnt`=k after that edge (RUN cycles numbered from 1).
- Timeout: `finish` rises together with `cycle_cnt` reaching TIMEOUT_CYCLES.
- Stall: `finish` rises after exactly IDLE_LIMIT consecutive idle RUN cycles.
- `restart` takes effect at the next edge; the next HOLD lasts a full RST_CYCLES.

## Test plan
- Reset release, RST_CYCLES=5 -> `sys_rst`=1 for exactly 5 edges; `status`=1 and `cycle_cnt`=0 after edge 5.
- Three writes to 18'h30000, then `mon_addr`=18'h30004, `mon_data`=0 in RUN cycle 40 -> `byte_cnt`=3, `status`=2, `exit_code`=0, `cycle_cnt`=40, `finish`=1; `sys_rst`=1 with HOLD_ON_DONE=1.
- TIMEOUT_CYCLES=100 and no exit -> `status`=4, `cycle_cnt`=100. With an exit write carrying data 8'h07 in cycle 100 -> `status`=3, `exit_code`=8'h07 (exit wins).
- IDLE_LIMIT=10: a write in cycle 3, then silence -> `status`=5 with `cycle_cnt`=13. A write arriving in cycle 13 instead resets the idle count and no stall is reported.
- `restart` pulse in DONE, and separately mid-RUN -> next edge gives `status`=0, `finish`=0, counters and `exit_code` 0; HOLD repeats for 5 edges.
- `rst_n` pulsed low between edges in RUN -> outputs reach reset values before the next edge.
